slow_clk_period_meter: RTL

SLOW_CLK_PERIOD_METER -- requirements
Module: slow_clk_period_meter

---
 rtl/slow_clk_period_meter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/slow_clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock cycles,
// publishing each rising-to-rising measurement over a valid/ready handshake.
module slow_clk_period_meter #(
  parameter int unsigned COUNT_WIDTH    = 28,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n,
  input  logic                   clk_in,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic [COUNT_WIDTH-1:0] high_out,
  output logic                   period_valid,
  input  logic                   period_ready,
  output logic                   timeout_out,
  output logic                   overrun_out
);

  typedef enum logic [1:0] {
    IDLE,
    MEAS_HIGH,
    MEAS_LOW,
    STALLED
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] high_lat_q, high_lat_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [COUNT_WIDTH-1:0] high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;

  logic                   clk_s;
  logic                   rise;
  logic                   fall;
  logic                   publish;
  logic                   timeout_hit;
  logic [COUNT_WIDTH-1:0] cnt_plus1;

  assign sync_d      = {sync_q[SYNC_STAGES-2:0], clk_in};
  assign clk_s       = sync_q[SYNC_STAGES-1];
  assign rise        = clk_s & ~edge_q;
  assign fall        = ~clk_s & edge_q;
  assign cnt_plus1   = cnt_q + ONE;
  // A rise always wins over the timeout, so the stall only fires on a genuinely silent input.
  assign timeout_hit = (cnt_plus1 == TIMEOUT_VAL) && !rise;

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == STALLED) ? cnt_q : cnt_plus1;
    high_lat_d = high_lat_q;
    timeout_d  = timeout_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    publish    = 1'b0;

    if (rise) cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS_HIGH;
        end else if (timeout_hit) begin
          state_d   = STALLED;
          timeout_d = 1'b1;
        end
      end
      MEAS_HIGH: begin
        if (timeout_hit) begin
          state_d   = STALLED;
          timeout_d = 1'b1;
        end else if (fall) begin
          high_lat_d = cnt_plus1;
          state_d    = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          publish = 1'b1;
          state_d = MEAS_HIGH;
        end else if (timeout_hit) begin
          state_d   = STALLED;
          timeout_d = 1'b1;
        end
      end
      STALLED: begin
        if (rise) begin
          state_d   = MEAS_HIGH;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept in the publish cycle frees the holding register for the new result.
    if (publish && (!valid_q || period_ready)) begin
      period_d = cnt_plus1;
      high_d   = high_lat_q;
      valid_d  = 1'b1;
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end

    if (publish && valid_q && !period_ready) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      edge_q     <= clk_s;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = valid_q;
  assign timeout_out  = timeout_q;
  assign overrun_out  = overrun_q;

endmodule
